// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared definitions for the sprite line multiplexer:
//   - channel FSM state encoding
//   - default values for the channel count, sprite width and pixel depth
//   - helper for index widths that stay legal when there is only one channel
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } chan_state_t;

    localparam int DEF_NSPR = 4;
    localparam int DEF_SPW  = 16;
    localparam int DEF_BPP  = 2;

    // Rightmost screen column; drawing never wraps past it.
    localparam logic [8:0] X_LAST = 9'd511;

    // Width of a channel index; a single channel still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_chan.sv
// sprite_chan
//   One sprite channel: a shadow descriptor written by loads, an active
//   descriptor copied from it at line_start, and the IDLE/ARMED/DRAW/DONE
//   sequencer that steps through the row with a 1/8-pixel accumulator.
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   line_start       copies shadow to active and re-arms the channel
//   pix_en, pixel_x  pixel strobe and current screen column
//   wr               write strobe for the shadow descriptor
//   wr_data/posx/step/flip/vis  shadow descriptor fields
//   pix              this channel's pixel for the current sample (0 = none)
module sprite_chan
    import sprite_pkg::*;
#(
    parameter int SPW = DEF_SPW,
    parameter int BPP = DEF_BPP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_start,
    input  logic               pix_en,
    input  logic [8:0]         pixel_x,
    input  logic               wr,
    input  logic [SPW*BPP-1:0] wr_data,
    input  logic [8:0]         wr_posx,
    input  logic [3:0]         wr_step,
    input  logic               wr_flip,
    input  logic               wr_vis,
    output logic [BPP-1:0]     pix
);

    localparam int IXW = $clog2(SPW);
    // Index bits above 3 fractional bits, plus a carry bit that marks "past the row".
    localparam int AW  = IXW + 4;

    logic [SPW*BPP-1:0] sh_data, act_data;
    logic [8:0]         sh_posx, act_posx;
    logic [3:0]         sh_step, act_step;
    logic               sh_flip, act_flip;
    logic               sh_vis;

    chan_state_t        state;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      acc_cur;
    logic [AW-1:0]      acc_nxt;
    logic [IXW-1:0]     pix_idx;
    logic [IXW-1:0]     slot;
    int unsigned        bit_lo;
    logic               start_hit;
    logic               last;

    // Shadow descriptor: only loads touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data <= '0;
            sh_posx <= '0;
            sh_step <= '0;
            sh_flip <= 1'b0;
            sh_vis  <= 1'b0;
        end else if (wr) begin
            sh_data <= wr_data;
            sh_posx <= wr_posx;
            sh_step <= wr_step;
            sh_flip <= wr_flip;
            sh_vis  <= wr_vis;
        end
    end

    // The first pixel is shown in the very sample that starts the sprite, so
    // the accumulator value used for a sample is 0 on that sample and the
    // stored acc afterwards; the register always holds the next sample's value.
    always_comb begin
        start_hit = (state == ST_ARMED) && pix_en && (pixel_x == act_posx)
                    && (act_step != '0);
        acc_cur   = (state == ST_DRAW) ? acc : '0;
        acc_nxt   = acc_cur + AW'(act_step);
        pix_idx   = acc_cur[AW-2:3];
        // Pixel 0 sits in the MSBs, so the slot counted from the LSB end is
        // the inverted index when unflipped and the index itself when flipped.
        slot      = act_flip ? pix_idx : ~pix_idx;
        bit_lo    = 32'(slot) * BPP;
        last      = acc_nxt[AW-1] || (pixel_x == X_LAST);
        pix       = '0;
        if (start_hit || (state == ST_DRAW)) begin
            pix = act_data[bit_lo +: BPP];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            act_data <= '0;
            act_posx <= '0;
            act_step <= '0;
            act_flip <= 1'b0;
        end else if (line_start) begin
            act_data <= sh_data;
            act_posx <= sh_posx;
            act_step <= sh_step;
            act_flip <= sh_flip;
            acc      <= '0;
            state    <= sh_vis ? ST_ARMED : ST_IDLE;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (start_hit) begin
                        acc   <= acc_nxt;
                        state <= last ? ST_DONE : ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (pix_en) begin
                        acc <= acc_nxt;
                        if (last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sprite_line_mux.sv
// sprite_line_mux
//   Per-line sprite engine: NSPR channels each produce a pixel per sample;
//   the lowest-indexed non-transparent channel wins. Outputs are registered
//   on pix_en, and a sticky collision flag is kept for the current line.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   line_start            start of horizontal blank; swaps shadow -> active
//   pix_en, pixel_x       pixel strobe and current half-resolution column
//   ld_valid/ld_ready     descriptor load handshake (ready low on line_start)
//   ld_idx, ld_data, ld_posx, ld_step, ld_flip, ld_en   descriptor fields
//   col, spr_id, hit      winning colour, channel and non-zero flag
//   coll                  two or more channels opaque in one sample this line
module sprite_line_mux
    import sprite_pkg::*;
#(
    parameter int NSPR = DEF_NSPR,
    parameter int SPW  = DEF_SPW,
    parameter int BPP  = DEF_BPP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     line_start,
    input  logic                     pix_en,
    input  logic [8:0]               pixel_x,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [idx_w(NSPR)-1:0]   ld_idx,
    input  logic [SPW*BPP-1:0]       ld_data,
    input  logic [8:0]               ld_posx,
    input  logic [3:0]               ld_step,
    input  logic                     ld_flip,
    input  logic                     ld_en,
    output logic [BPP-1:0]           col,
    output logic [idx_w(NSPR)-1:0]   spr_id,
    output logic                     hit,
    output logic                     coll
);

    localparam int IW = idx_w(NSPR);

    logic           ld_fire;
    logic [BPP-1:0] pix [NSPR];
    logic [BPP-1:0] win_col;
    logic [IW-1:0]  win_id;
    logic           found;
    logic           multi;

    // Loads are refused during the swap cycle so a write can never race it.
    assign ld_ready = ~line_start;
    assign ld_fire  = ld_valid & ld_ready;

    for (genvar g = 0; g < NSPR; g++) begin : g_chan
        sprite_chan #(
            .SPW (SPW),
            .BPP (BPP)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .line_start (line_start),
            .pix_en     (pix_en),
            .pixel_x    (pixel_x),
            .wr         (ld_fire && (ld_idx == IW'(g))),
            .wr_data    (ld_data),
            .wr_posx    (ld_posx),
            .wr_step    (ld_step),
            .wr_flip    (ld_flip),
            .wr_vis     (ld_en),
            .pix        (pix[g])
        );
    end

    // Fixed priority: lowest index wins; a second opaque channel is a collision.
    always_comb begin
        win_col = '0;
        win_id  = '0;
        found   = 1'b0;
        multi   = 1'b0;
        for (int unsigned i = 0; i < NSPR; i++) begin
            if (pix[i] != '0) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    found   = 1'b1;
                    win_col = pix[i];
                    win_id  = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            spr_id <= '0;
            hit    <= 1'b0;
            coll   <= 1'b0;
        end else begin
            if (pix_en) begin
                col    <= win_col;
                spr_id <= win_id;
                hit    <= found;
            end
            // Clear has priority over a same-cycle set.
            if (line_start) begin
                coll <= 1'b0;
            end else if (pix_en && multi) begin
                coll <= 1'b1;
            end
        end
    end

endmodule
